// File: rtl/matrix_mac_sequencer_if.sv
// Bus between the matrix MAC sequencer and its environment: control/matrices from the
// coprocessor top, operand/product pair to and from the multiplier. slave = sequencer side.
interface matrix_mac_sequencer_if #(
   parameter int DIM_MAX = 5,
   parameter int DATA_W  = 8
);
   localparam int MAT_W = DIM_MAX * DIM_MAX * DATA_W;

   logic              start;
   logic [2:0]        size;
   logic [MAT_W-1:0]  mat_a;
   logic [MAT_W-1:0]  mat_b;
   logic [DATA_W-1:0] mul_a;
   logic [DATA_W-1:0] mul_b;
   logic [DATA_W-1:0] mul_prod;
   logic              mul_ovf;
   logic [MAT_W-1:0]  mat_c;
   logic              busy;
   logic              done;
   logic              ovf;

   modport master (
      output start, size, mat_a, mat_b, mul_prod, mul_ovf,
      input  mul_a, mul_b, mat_c, busy, done, ovf
   );

   modport slave (
      input  start, size, mat_a, mat_b, mul_prod, mul_ovf,
      output mul_a, mul_b, mat_c, busy, done, ovf
   );
endinterface

// File: rtl/matrix_mac_sequencer.sv
// Drives one external int8 multiplier through an NxN product C = A x B, one MAC per cycle.
// done pulses N*N*(N+1)+1 cycles after start; no backpressure, start is ignored outside IDLE.
module matrix_mac_sequencer #(
   parameter int DIM_MAX = 5,
   parameter int DATA_W  = 8,
   parameter int ACC_W   = 16
) (
   input logic                   clk,
   input logic                   rst,
   matrix_mac_sequencer_if.slave bus
);
   localparam int MAT_W = DIM_MAX * DIM_MAX * DATA_W;
   localparam logic [2:0] N_MIN = 3'd2;
   localparam logic [2:0] N_MAX = 3'(DIM_MAX);
   localparam logic signed [ACC_W-1:0] SAT_HI = ACC_W'((2 ** (DATA_W - 1)) - 1);
   localparam logic signed [ACC_W-1:0] SAT_LO = ~SAT_HI;

   typedef enum logic [1:0] {IDLE, MAC, STORE, DONE} state_t;
   state_t state, state_nxt;

   logic [MAT_W-1:0]        a_q, b_q, c_q;
   logic [2:0]              n_q, i_q, j_q, k_q, n_clamp;
   logic signed [ACC_W-1:0] acc_q, prod_ext;
   logic [DATA_W-1:0]       acc_sat;
   logic                    acc_clip, ovf_q, done_q, busy_q, last_k, last_col, last_elem;

   function automatic int elem(input logic [2:0] r, input logic [2:0] c);
      return (int'(r) * DIM_MAX + int'(c)) * DATA_W;
   endfunction

   always_comb begin
      n_clamp = bus.size;
      if (bus.size < N_MIN)      n_clamp = N_MIN;
      else if (bus.size > N_MAX) n_clamp = N_MAX;
   end

   assign last_k    = (k_q == n_q - 3'd1);
   assign last_col  = (j_q == n_q - 3'd1);
   assign last_elem = last_col && (i_q == n_q - 3'd1);
   assign prod_ext  = {{(ACC_W - DATA_W){bus.mul_prod[DATA_W-1]}}, bus.mul_prod};

   // Saturation only happens at STORE; the accumulator itself is wide enough never to wrap.
   always_comb begin
      acc_clip = 1'b1;
      acc_sat  = SAT_HI[DATA_W-1:0];
      if (acc_q < SAT_LO) begin
         acc_sat = SAT_LO[DATA_W-1:0];
      end else if (acc_q <= SAT_HI) begin
         acc_clip = 1'b0;
         acc_sat  = acc_q[DATA_W-1:0];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (bus.start) state_nxt = MAC;
         MAC:     if (last_k) state_nxt = STORE;
         STORE:   state_nxt = last_elem ? DONE : MAC;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         a_q    <= '0;
         b_q    <= '0;
         c_q    <= '0;
         n_q    <= '0;
         i_q    <= '0;
         j_q    <= '0;
         k_q    <= '0;
         acc_q  <= '0;
         ovf_q  <= 1'b0;
         done_q <= 1'b0;
         busy_q <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state)
            IDLE: if (bus.start) begin
               a_q    <= bus.mat_a;
               b_q    <= bus.mat_b;
               n_q    <= n_clamp;
               i_q    <= '0;
               j_q    <= '0;
               k_q    <= '0;
               acc_q  <= '0;
               ovf_q  <= 1'b0;
               c_q    <= '0;
               busy_q <= 1'b1;
            end
            MAC: begin
               acc_q <= acc_q + prod_ext;
               ovf_q <= ovf_q | bus.mul_ovf;
               k_q   <= last_k ? 3'd0 : k_q + 3'd1;
            end
            STORE: begin
               c_q[elem(i_q, j_q) +: DATA_W] <= acc_sat;
               if (acc_clip) ovf_q <= 1'b1;
               acc_q <= '0;
               if (last_elem) begin
                  i_q    <= '0;
                  j_q    <= '0;
                  busy_q <= 1'b0;
               end else if (last_col) begin
                  j_q <= '0;
                  i_q <= i_q + 3'd1;
               end else begin
                  j_q <= j_q + 3'd1;
               end
            end
            DONE:    done_q <= 1'b1;
            default: ;
         endcase
      end
   end

   always_comb begin
      bus.mul_a = '0;
      bus.mul_b = '0;
      if (state == MAC) begin
         bus.mul_a = a_q[elem(i_q, k_q) +: DATA_W];
         bus.mul_b = b_q[elem(k_q, j_q) +: DATA_W];
      end
   end

   assign bus.mat_c = c_q;
   assign bus.busy  = busy_q;
   assign bus.done  = done_q;
   assign bus.ovf   = ovf_q;
endmodule

// File: tb/tb_matrix_mac_sequencer.sv
// Scoreboarded bench: stimulus pushes reference-model results, a monitor pops them on done.
module tb_matrix_mac_sequencer;
   localparam int DIM_MAX = 5;
   localparam int DATA_W  = 8;
   localparam int ACC_W   = 16;
   localparam int MAT_W   = DIM_MAX * DIM_MAX * DATA_W;

   typedef struct {
      logic [MAT_W-1:0] c;
      logic             ovf;
      int               done_cyc;
   } exp_t;

   logic clk = 1'b0;
   logic rst;
   int   cyc = 0;
   int   checks = 0;
   int   errors = 0;
   exp_t exp_q[$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   matrix_mac_sequencer_if #(.DIM_MAX(DIM_MAX), .DATA_W(DATA_W)) bus ();

   matrix_mac_sequencer #(.DIM_MAX(DIM_MAX), .DATA_W(DATA_W), .ACC_W(ACC_W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   // Saturating int8 multiplier standing in for the real one.
   function automatic logic [8:0] mul_model(input logic [7:0] a, input logic [7:0] b);
      int p;
      p = int'($signed(a)) * int'($signed(b));
      if (p > 127)  return {1'b1, 8'h7f};
      if (p < -128) return {1'b1, 8'h80};
      return {1'b0, p[7:0]};
   endfunction

   assign {bus.mul_ovf, bus.mul_prod} = mul_model(bus.mul_a, bus.mul_b);

   function automatic int el(input logic [MAT_W-1:0] m, input int r, input int c);
      logic [7:0] v;
      v = m[(r * DIM_MAX + c) * 8 +: 8];
      return int'($signed(v));
   endfunction

   function automatic void put(inout logic [MAT_W-1:0] m, input int r, input int c, input int v);
      m[(r * DIM_MAX + c) * 8 +: 8] = 8'(v);
   endfunction

   function automatic int clampn(input logic [2:0] sz);
      if (sz < 3'd2) return 2;
      if (sz > 3'd5) return 5;
      return int'(sz);
   endfunction

   function automatic void ref_model(input logic [MAT_W-1:0] a, input logic [MAT_W-1:0] b,
                                     input int n, output logic [MAT_W-1:0] c, output logic ov);
      c  = '0;
      ov = 1'b0;
      for (int i = 0; i < n; i++) begin
         for (int j = 0; j < n; j++) begin
            int sum;
            sum = 0;
            for (int k = 0; k < n; k++) begin
               int p;
               p = el(a, i, k) * el(b, k, j);
               if (p > 127) begin p = 127; ov = 1'b1; end
               else if (p < -128) begin p = -128; ov = 1'b1; end
               sum += p;
            end
            if (sum > 127) begin sum = 127; ov = 1'b1; end
            else if (sum < -128) begin sum = -128; ov = 1'b1; end
            put(c, i, j, sum);
         end
      end
   endfunction

   function automatic logic [MAT_W-1:0] rand_mat(input int lim);
      logic [MAT_W-1:0] m;
      m = '0;
      for (int e = 0; e < DIM_MAX * DIM_MAX; e++)
         m[e * 8 +: 8] = 8'(int'($urandom_range(0, 2 * lim)) - lim);
      return m;
   endfunction

   task automatic chk(input string name, input logic [MAT_W-1:0] act, input logic [MAT_W-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Monitor: every done pulse must match the oldest outstanding expectation.
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         chk("mul_idle_zero", MAT_W'(!bus.busy && (bus.mul_a != 0 || bus.mul_b != 0)), '0);
         if (bus.done) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_done", MAT_W'(1), MAT_W'(0));
            end else begin
               e = exp_q.pop_front();
               chk("latency_edge", MAT_W'(cyc), MAT_W'(e.done_cyc));
               chk("mat_c", bus.mat_c, e.c);
               chk("ovf", MAT_W'(bus.ovf), MAT_W'(e.ovf));
            end
         end
      end
   end

   // Called at a negedge; returns at the negedge after the start edge.
   task automatic issue(input logic [MAT_W-1:0] a, input logic [MAT_W-1:0] b,
                        input logic [2:0] sz, input bit scramble, output int s_edge);
      exp_t e;
      int   n;
      n = clampn(sz);
      ref_model(a, b, n, e.c, e.ovf);
      s_edge     = cyc + 1;
      e.done_cyc = s_edge + n * n * (n + 1) + 1;
      exp_q.push_back(e);
      bus.start = 1'b1;
      bus.size  = sz;
      bus.mat_a = a;
      bus.mat_b = b;
      @(posedge clk);
      #1;
      chk("busy_after_start", MAT_W'(bus.busy), MAT_W'(1));
      @(negedge clk);
      bus.start = 1'b0;
      if (scramble) begin
         bus.mat_a = rand_mat(128);
         bus.mat_b = rand_mat(128);
         bus.size  = 3'($urandom_range(0, 7));
      end
   endtask

   task automatic pulse_mid(input int k);
      repeat (k) @(negedge clk);
      bus.start = 1'b1;
      bus.mat_a = rand_mat(128);
      bus.mat_b = rand_mat(128);
      bus.size  = 3'($urandom_range(0, 7));
      @(negedge clk);
      bus.start = 1'b0;
   endtask

   task automatic wait_done();
      for (int t = 0; t < 400; t++) begin
         @(negedge clk);
         if (bus.done) return;
      end
      chk("done_timeout", MAT_W'(1), MAT_W'(0));
   endtask

   initial begin
      logic [MAT_W-1:0] a, b;
      int s;
      rst       = 1'b1;
      bus.start = 1'b0;
      bus.size  = 3'd0;
      bus.mat_a = '0;
      bus.mat_b = '0;
      repeat (3) @(negedge clk);
      chk("rst_busy", MAT_W'(bus.busy), '0);
      chk("rst_done", MAT_W'(bus.done), '0);
      chk("rst_ovf", MAT_W'(bus.ovf), '0);
      chk("rst_mat_c", bus.mat_c, '0);
      chk("rst_mul_a", MAT_W'(bus.mul_a), '0);
      rst = 1'b0;
      @(negedge clk);

      a = '0; b = '0;
      put(a, 0, 0, 1); put(a, 0, 1, 2); put(a, 1, 0, 3); put(a, 1, 1, 4);
      put(b, 0, 0, 5); put(b, 0, 1, 6); put(b, 1, 0, 7); put(b, 1, 1, 8);
      issue(a, b, 3'd2, 1'b1, s);
      wait_done();

      a = '0; b = '0;
      for (int r = 0; r < 5; r++) begin
         put(a, r, r, 1);
         for (int c = 0; c < 5; c++) put(b, r, c, r * 5 + c);
      end
      issue(a, b, 3'd5, 1'b1, s);
      wait_done();

      a = '0; b = '0;
      for (int r = 0; r < 5; r++)
         for (int c = 0; c < 5; c++) begin put(a, r, c, 10); put(b, r, c, 10); end
      issue(a, b, 3'd3, 1'b1, s);
      wait_done();
      for (int r = 0; r < 5; r++)
         for (int c = 0; c < 5; c++) put(a, r, c, -10);
      issue(a, b, 3'd3, 1'b1, s);
      wait_done();
      issue(rand_mat(5), rand_mat(5), 3'd2, 1'b1, s);
      wait_done();

      issue(rand_mat(20), rand_mat(20), 3'd7, 1'b1, s);
      pulse_mid(20);
      wait_done();
      issue(rand_mat(20), rand_mat(20), 3'd1, 1'b1, s);
      pulse_mid(3);
      wait_done();

      // start during the DONE cycle must be dropped
      issue(rand_mat(9), rand_mat(9), 3'd2, 1'b0, s);
      for (int t = 0; t < 100 && bus.busy; t++) @(negedge clk);
      bus.start = 1'b1;
      bus.size  = 3'd3;
      @(negedge clk);
      bus.start = 1'b0;
      repeat (3) @(negedge clk);
      chk("start_in_done_ignored", MAT_W'(bus.busy), '0);

      for (int r = 0; r < 10; r++) begin
         issue(rand_mat(int'($urandom_range(3, 128))), rand_mat(int'($urandom_range(3, 128))),
               3'($urandom_range(0, 7)), 1'b1, s);
         if ($urandom_range(0, 1) == 1) pulse_mid(int'($urandom_range(1, 8)));
         wait_done();
      end

      // Reset at edge 20 of an N=4 run abandons it without a done pulse.
      issue(rand_mat(30), rand_mat(30), 3'd4, 1'b0, s);
      while (cyc < s + 19) @(negedge clk);
      rst = 1'b1;
      void'(exp_q.pop_back());
      @(posedge clk);
      #1;
      chk("abort_busy", MAT_W'(bus.busy), '0);
      chk("abort_done", MAT_W'(bus.done), '0);
      chk("abort_mat_c", bus.mat_c, '0);
      chk("abort_ovf", MAT_W'(bus.ovf), '0);
      chk("abort_mul_a", MAT_W'(bus.mul_a), '0);
      @(negedge clk);
      rst = 1'b0;
      repeat (150) @(negedge clk);

      chk("queue_drained", MAT_W'(exp_q.size()), '0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
